// File: rtl/adder_err_pkg.sv
// adder_err_pkg: shared types, widths and saturating adders for the adder error monitor
package adder_err_pkg;

    localparam int OP_W  = 5;
    localparam int SUM_W = 6;
    localparam int ERR_W = 7;

    typedef enum logic [1:0] {ACC, DRAIN, REPORT} st_e;

    // unsigned add clamped to the all-ones value of a w-bit field (w <= 32)
    function automatic logic [31:0] sat_addu(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return s > lim ? lim[31:0] : s[31:0];
    endfunction

    // signed add clamped symmetrically to +/-(2^(w-1)-1) of a w-bit field
    function automatic logic signed [31:0] sat_adds(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
        logic signed [32:0] s;
        logic signed [32:0] lim;
        logic signed [32:0] nlim;
        s    = {a[31], a} + {b[31], b};
        lim  = (33'sd1 <<< (w - 1)) - 33'sd1;
        nlim = -lim;
        return s > lim ? lim[31:0] : (s < nlim ? nlim[31:0] : s[31:0]);
    endfunction

endpackage

// File: rtl/adder_err_calc.sv
// adder_err_calc: combinational exact sum, signed error, magnitude and nonzero flag
module adder_err_calc
    import adder_err_pkg::*;
(
    input  logic        [OP_W-1:0]  op_a,
    input  logic        [OP_W-1:0]  op_b,
    input  logic        [SUM_W-1:0] approx_sum,
    output logic signed [ERR_W-1:0] err,
    output logic        [SUM_W-1:0] abs_err,
    output logic                    nz
);

    logic [SUM_W-1:0] exact;

    assign exact   = SUM_W'(op_a) + SUM_W'(op_b);
    assign err     = ERR_W'(approx_sum) - ERR_W'(exact);
    assign abs_err = err[ERR_W-1] ? SUM_W'(-err) : SUM_W'(err);
    assign nz      = |err;

endmodule

// File: rtl/adder_err_monitor.sv
// adder_err_monitor: windowed error statistics for the approximate 5-bit adder,
// reported through a valid/ready handshake with input back-pressure while pending.
module adder_err_monitor
    import adder_err_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    input  logic [SUM_W-1:0]  approx_sum,
    output logic              rep_valid,
    input  logic              rep_ready,
    output logic [ACC_W-1:0]  rep_samples,
    output logic [ACC_W-1:0]  rep_err_cnt,
    output logic [ACC_W-1:0]  rep_err_sum,
    output logic [ACC_W-1:0]  rep_bias,
    output logic [SUM_W-1:0]  rep_err_max
);

    localparam logic signed [ACC_W-1:0] B_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] B_MIN = -B_MAX;

    st_e                     st, nxt;
    logic                    rdy_q;
    logic                    s1_v, s1_nz;
    logic signed [ERR_W-1:0] s1_err, c_err;
    logic        [SUM_W-1:0] s1_abs, c_abs, mx;
    logic                    c_nz;
    logic        [ACC_W-1:0] cnt, err_cnt, err_sum;
    logic signed [ACC_W-1:0] bias;
    logic                    accept, last, bias_sat, wipe;

    adder_err_calc u_calc (
        .op_a       (op_a),
        .op_b       (op_b),
        .approx_sum (approx_sum),
        .err        (c_err),
        .abs_err    (c_abs),
        .nz         (c_nz)
    );

    assign in_ready = rdy_q && st == ACC && !clr;
    assign accept   = in_valid && in_ready;
    // the sample in stage 1 has been accepted but not yet counted
    assign last     = accept && (cnt + ACC_W'(s1_v) == ACC_W'(WINDOW - 1));
    assign bias_sat = bias == B_MAX || bias == B_MIN;
    assign wipe     = clr || (st == REPORT && rep_ready);

    always_comb begin
        nxt = st;
        if (clr)
            nxt = ACC;
        else if (st == ACC)
            nxt = last ? DRAIN : ACC;
        else if (st == DRAIN)
            nxt = REPORT;
        else
            nxt = rep_ready ? ACC : REPORT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ACC;
            rdy_q   <= 1'b0;
            s1_v    <= 1'b0;
            s1_err  <= '0;
            s1_abs  <= '0;
            s1_nz   <= 1'b0;
            cnt     <= '0;
            err_cnt <= '0;
            err_sum <= '0;
            bias    <= '0;
            mx      <= '0;
        end else begin
            st    <= nxt;
            rdy_q <= 1'b1;
            s1_v  <= accept;
            if (accept) begin
                s1_err <= c_err;
                s1_abs <= c_abs;
                s1_nz  <= c_nz;
            end
            if (wipe) begin
                cnt     <= '0;
                err_cnt <= '0;
                err_sum <= '0;
                bias    <= '0;
                mx      <= '0;
            end else if (s1_v) begin
                cnt     <= cnt + ACC_W'(1);
                err_cnt <= err_cnt + ACC_W'(s1_nz);
                err_sum <= ACC_W'(sat_addu(32'(err_sum), 32'(s1_abs), ACC_W));
                bias    <= bias_sat ? bias : ACC_W'(sat_adds(32'(bias), 32'(s1_err), ACC_W));
                mx      <= s1_abs > mx ? s1_abs : mx;
            end
        end
    end

    assign rep_valid   = st == REPORT;
    assign rep_samples = cnt;
    assign rep_err_cnt = err_cnt;
    assign rep_err_sum = err_sum;
    assign rep_bias    = bias;
    assign rep_err_max = mx;

endmodule

// File: tb/tb_adder_err_monitor.sv
// tb_adder_err_monitor: randomized windows against a sample-level statistics model,
// on a WINDOW=4/ACC_W=16 instance and a WINDOW=8/ACC_W=8 saturation instance.
module tb_adder_err_monitor;

    logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0, iv = 1'b0, rr = 1'b0, sel = 1'b0;
    logic [4:0] op_a = '0, op_b = '0;
    logic [5:0] approx = '0;

    logic        rdy_a, rv_a, rdy_b, rv_b;
    logic [15:0] smp_a, ec_a, es_a, bs_a;
    logic [7:0]  smp_b, ec_b, es_b, bs_b;
    logic [5:0]  mx_a, mx_b;

    logic rdy, rv;
    int   smp, ec, es, bs, mx;
    int   n_cmp = 0, n_bad = 0;

    int ta[4] = '{3, 0, 31, 7};
    int tb[4] = '{5, 0, 31, 1};
    int ts[4] = '{10, 0, 60, 8};

    always #5 clk = ~clk;

    adder_err_monitor #(.WINDOW(4), .ACC_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv && !sel), .in_ready(rdy_a),
        .op_a(op_a), .op_b(op_b), .approx_sum(approx), .rep_valid(rv_a), .rep_ready(rr && !sel),
        .rep_samples(smp_a), .rep_err_cnt(ec_a), .rep_err_sum(es_a), .rep_bias(bs_a), .rep_err_max(mx_a)
    );

    adder_err_monitor #(.WINDOW(8), .ACC_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv && sel), .in_ready(rdy_b),
        .op_a(op_a), .op_b(op_b), .approx_sum(approx), .rep_valid(rv_b), .rep_ready(rr && sel),
        .rep_samples(smp_b), .rep_err_cnt(ec_b), .rep_err_sum(es_b), .rep_bias(bs_b), .rep_err_max(mx_b)
    );

    always_comb begin
        rdy = sel ? rdy_b : rdy_a;
        rv  = sel ? rv_b : rv_a;
        smp = sel ? int'(smp_b) : int'(smp_a);
        ec  = sel ? int'(ec_b) : int'(ec_a);
        es  = sel ? int'(es_b) : int'(es_a);
        bs  = sel ? int'($signed(bs_b)) : int'($signed(bs_a));
        mx  = sel ? int'(mx_b) : int'(mx_a);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    task automatic chk_idle_clean();
        chk("rep_valid_clear", int'(rv), 0);
        chk("samples_clear", smp, 0);
        chk("err_cnt_clear", ec, 0);
        chk("err_sum_clear", es, 0);
        chk("err_max_clear", mx, 0);
    endtask

    // mode 0 exact, 1 fixed table, 2 max positive error, 3 fully random
    task automatic feed_window(input int mode, input int hold, input bit ack);
        int w, aw, lim, umax, e, i, a, b, s;
        int x_ec, x_es, x_eb, x_em;
        bit go;
        w = sel ? 8 : 4;
        aw = sel ? 8 : 16;
        lim = (1 << (aw - 1)) - 1;
        umax = (1 << aw) - 1;
        x_ec = 0; x_es = 0; x_eb = 0; x_em = 0; i = 0;
        while (i < w) begin
            @(negedge clk);
            go = $urandom_range(0, 3) != 0;
            a = int'($urandom_range(0, 31));
            b = int'($urandom_range(0, 31));
            s = mode == 0 ? a + b : int'($urandom_range(0, 63));
            if (mode == 1) begin a = ta[i]; b = tb[i]; s = ts[i]; end
            if (mode == 2) begin a = 0; b = 0; s = 63; end
            op_a = 5'(a); op_b = 5'(b); approx = 6'(s);
            iv = go;
            rr = 1'($urandom_range(0, 1));
            #1 chk("in_ready_acc", int'(rdy), 1);
            chk("rep_valid_acc", int'(rv), 0);
            @(posedge clk);
            if (go) begin
                e = s - (a + b);
                x_ec += (e != 0) ? 1 : 0;
                x_es += e < 0 ? -e : e;
                x_em = (e < 0 ? -e : e) > x_em ? (e < 0 ? -e : e) : x_em;
                if (x_eb != lim && x_eb != -lim)
                    x_eb = x_eb + e > lim ? lim : (x_eb + e < -lim ? -lim : x_eb + e);
                i++;
            end
        end
        if (x_es > umax) x_es = umax;
        @(negedge clk);
        iv = 1'b1;
        rr = 1'b1;
        #1 chk("in_ready_drain", int'(rdy), 0);
        chk("rep_valid_drain", int'(rv), 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            rr = 1'b0;
            #1 chk("rep_valid", int'(rv), 1);
            chk("in_ready_rep", int'(rdy), 0);
            chk("samples", smp, w);
            chk("err_cnt", ec, x_ec);
            chk("err_sum", es, x_es);
            chk("bias", bs, x_eb);
            chk("err_max", mx, x_em);
        end
        if (ack) begin
            rr = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rr = 1'b0;
            iv = 1'b0;
            #1 chk("in_ready_after_ack", int'(rdy), 1);
            chk_idle_clean();
            chk("bias_clear", bs, 0);
        end else begin
            iv = 1'b0;
        end
    endtask

    initial begin
        #1 chk("in_ready_reset", int'(rdy), 0);
        chk_idle_clean();
        chk("bias_reset", bs, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_ready_release", int'(rdy), 0);
        @(negedge clk);
        #1 chk("in_ready_first", int'(rdy), 1);

        feed_window(0, 1, 1'b1);
        feed_window(1, 10, 1'b1);
        repeat (4) feed_window(3, int'($urandom_range(1, 4)), 1'b1);

        // clr after two erroneous samples discards them, including the one in stage 1
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            op_a = 5'd1; op_b = 5'd1; approx = 6'd9; iv = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        clr = 1'b1;
        #1 chk("in_ready_clr", int'(rdy), 0);
        @(negedge clk);
        clr = 1'b0;
        iv = 1'b0;
        #1 chk_idle_clean();
        @(negedge clk);
        #1 chk("err_sum_after_clr", es, 0);
        chk("samples_after_clr", smp, 0);
        feed_window(0, 1, 1'b1);

        // clr drops a pending report
        feed_window(3, 2, 1'b0);
        @(negedge clk);
        iv = 1'b1;
        clr = 1'b1;
        #1 chk("in_ready_clr_rep", int'(rdy), 0);
        @(negedge clk);
        clr = 1'b0;
        iv = 1'b0;
        #1 chk("in_ready_after_clr", int'(rdy), 1);
        chk_idle_clean();

        sel = 1'b1;
        feed_window(2, 3, 1'b1);
        repeat (3) feed_window(3, 2, 1'b1);
        sel = 1'b0;

        // asynchronous reset in the middle of a report
        feed_window(1, 2, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("in_ready_rst", int'(rdy), 0);
        chk_idle_clean();
        chk("bias_rst", bs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_ready_rst_release", int'(rdy), 0);
        @(negedge clk);
        #1 chk("in_ready_rst_first", int'(rdy), 1);
        chk_idle_clean();
        feed_window(3, 1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
